// File: rtl/clock_distribution_seq_if.sv
// Control/status bundle for the IDAC clock distribution sequencer.
// The DUT uses the slave modport; the bench drives through master.
interface clock_distribution_seq_if #(
  parameter int N_THERM = 17,
  parameter int N_BIN   = 7,
  parameter int CNT_W   = 8
);
  logic               pdb;
  logic [1:0]         atb_ena;
  logic               fault_clr;
  logic [N_THERM-1:0] clkout_therm;
  logic [N_THERM-1:0] clkoutb_therm;
  logic [N_BIN-1:0]   clkout_bin;
  logic [N_BIN-1:0]   clkoutb_bin;
  logic [1:0]         state;
  logic               ready;
  logic               fault_sticky;
  logic [CNT_W-1:0]   fault_cnt;
  logic               atb_drive;

  modport master (
    output pdb, atb_ena, fault_clr,
    input  clkout_therm, clkoutb_therm, clkout_bin, clkoutb_bin,
    input  state, ready, fault_sticky, fault_cnt, atb_drive
  );

  modport slave (
    input  pdb, atb_ena, fault_clr,
    output clkout_therm, clkoutb_therm, clkout_bin, clkoutb_bin,
    output state, ready, fault_sticky, fault_cnt, atb_drive
  );
endinterface

// File: rtl/clock_distribution_seq.sv
// Segmented IDAC clock distribution: supply-qualified power-up sequencer with
// staggered, glitch-free per-channel clock gates and supply fault tracking.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_OFF    | all channels gated off, waiting for pdb_s & sok_s
// S_SETTLE | supplies must stay qualified for SETTLE_CYC cycles
// S_RAMP   | one channel enabled every STAGGER_CYC cycles
// S_ON     | all channels running, ready=1
module clock_distribution_seq #(
  parameter int N_THERM     = 17,
  parameter int N_BIN       = 7,
  parameter int SETTLE_CYC  = 16,
  parameter int STAGGER_CYC = 2,
  parameter int CNT_W       = 8,
  parameter int TDEL_PS     = 50
) (
  input  logic clkin,
  input  logic rst,
  input  real  iref_25ua,
  input  real  vddana_0p8,
  input  real  vssana,
  output real  atb1,
  output real  atb0,
  clock_distribution_seq_if.slave bus
);

  localparam int NCH   = N_BIN + N_THERM;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_OFF    = 2'b00;
  localparam logic [1:0] S_SETTLE = 2'b01;
  localparam logic [1:0] S_RAMP   = 2'b10;
  localparam logic [1:0] S_ON     = 2'b11;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NCH - 1);

  // The output delay is a behavioural-model attribute; this gate path is zero-delay.
  if (TDEL_PS < 0) begin : g_bad_tdel
    $error("TDEL_PS must be non-negative");
  end
  if (STAGGER_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_timing
    $error("SETTLE_CYC and STAGGER_CYC must be at least 1");
  end

  logic             supply_ok;
  logic             pdb_m, pdb_s, sok_m, sok_s;
  logic             warned;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [NCH-1:0]   ch_en;
  logic             fault_sticky_r;
  logic [CNT_W-1:0] fault_cnt_r;
  logic             fault_evt;
  logic             ready;
  logic [NCH-1:0]   lat_en, latb_en, clk_g, clkb_g;
  logic             atb_drive;

  always_comb begin
    supply_ok = (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84) &&
                (vssana >= -0.05) && (vssana <= 0.05) &&
                (iref_25ua >= 22.5e-6) && (iref_25ua <= 27.5e-6);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pdb_m <= 1'b0;
      pdb_s <= 1'b0;
      sok_m <= 1'b0;
      sok_s <= 1'b0;
    end else begin
      pdb_m <= bus.pdb;
      pdb_s <= pdb_m;
      sok_m <= supply_ok;
      sok_s <= sok_m;
    end
  end

  // One warning per excursion rather than one per cycle.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      warned <= 1'b0;
    end else if (supply_ok) begin
      warned <= 1'b0;
    end else if (!warned) begin
      warned <= 1'b1;
      $warning("clock_distribution_seq: supply or reference out of range");
    end
  end

  assign fault_evt = pdb_s && !sok_s && (state_r == S_RAMP || state_r == S_ON);
  assign ready     = (state_r == S_ON);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_r <= S_OFF;
      cnt     <= '0;
      idx     <= '0;
      ch_en   <= '0;
    end else begin
      case (state_r)
        S_OFF: begin
          ch_en <= '0;
          if (pdb_s && sok_s) begin
            state_r <= S_SETTLE;
            cnt     <= '0;
          end
        end
        S_SETTLE: begin
          if (!pdb_s || !sok_s) begin
            state_r <= S_OFF;
          end else if (cnt == SETTLE_LAST) begin
            state_r <= S_RAMP;
            cnt     <= '0;
            idx     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RAMP: begin
          if (!pdb_s || !sok_s) begin
            state_r <= S_OFF;
            ch_en   <= '0;
          end else if (cnt == STAGGER_LAST) begin
            ch_en[idx] <= 1'b1;
            cnt        <= '0;
            if (idx == IDX_LAST) state_r <= S_ON;
            else                 idx     <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ON: begin
          if (!pdb_s || !sok_s) begin
            state_r <= S_OFF;
            ch_en   <= '0;
          end
        end
        default: begin
          state_r <= S_OFF;
          ch_en   <= '0;
        end
      endcase
    end
  end

  // A fault on the same edge as fault_clr keeps the flag set.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      fault_sticky_r <= 1'b0;
      fault_cnt_r    <= '0;
    end else if (fault_evt) begin
      fault_sticky_r <= 1'b1;
      if (fault_cnt_r != '1) fault_cnt_r <= fault_cnt_r + 1'b1;
    end else if (bus.fault_clr) begin
      fault_sticky_r <= 1'b0;
    end
  end

  // ch_en moves on the rising edge, so each latch is closed whenever its output phase is live.
  always_latch begin
    if (rst)         lat_en <= '0;
    else if (!clkin) lat_en <= ch_en;
  end

  always_latch begin
    if (rst)        latb_en <= '0;
    else if (clkin) latb_en <= ch_en;
  end

  assign clk_g  = {NCH{clkin}}  & lat_en;
  assign clkb_g = {NCH{~clkin}} & latb_en;

  assign bus.clkout_bin    = clk_g[N_BIN-1:0];
  assign bus.clkoutb_bin   = clkb_g[N_BIN-1:0];
  assign bus.clkout_therm  = clk_g[NCH-1:N_BIN];
  assign bus.clkoutb_therm = clkb_g[NCH-1:N_BIN];

  // A real net cannot float, so atb_drive=0 stands for both test lines at high-Z.
  always_comb begin
    atb1      = 0.0;
    atb0      = 0.0;
    atb_drive = 1'b0;
    if (pdb_s && bus.atb_ena != 2'b00) begin
      atb_drive = 1'b1;
      atb0      = vssana;
      case (bus.atb_ena)
        2'b01:   atb1 = vddana_0p8;
        2'b10:   atb1 = iref_25ua;
        default: atb1 = ready ? vddana_0p8 : vssana;
      endcase
    end
  end

  assign bus.state        = state_r;
  assign bus.ready        = ready;
  assign bus.fault_sticky = fault_sticky_r;
  assign bus.fault_cnt    = fault_cnt_r;
  assign bus.atb_drive    = atb_drive;

endmodule

// File: tb/tb_clock_distribution_seq.sv
// Bench for clock_distribution_seq: directed power-up/fault scenarios plus random
// supply/pdb traffic, checked every half-cycle against a timeline model.
module tb_clock_distribution_seq;
  localparam int N_THERM = 17, N_BIN = 7, NCH = 24;
  localparam int SETTLE_CYC = 16, STAGGER_CYC = 2, CNT_W = 8;

  logic clkin = 1'b0;
  logic rst   = 1'b0;
  real  iref_25ua  = 25.0e-6;
  real  vddana_0p8 = 0.8;
  real  vssana     = 0.0;
  real  atb1, atb0;

  clock_distribution_seq_if #(.N_THERM(N_THERM), .N_BIN(N_BIN), .CNT_W(CNT_W)) bus ();

  clock_distribution_seq #(
    .N_THERM(N_THERM), .N_BIN(N_BIN), .SETTLE_CYC(SETTLE_CYC),
    .STAGGER_CYC(STAGGER_CYC), .CNT_W(CNT_W), .TDEL_PS(50)
  ) dut (
    .clkin(clkin), .rst(rst),
    .iref_25ua(iref_25ua), .vddana_0p8(vddana_0p8), .vssana(vssana),
    .atb1(atb1), .atb0(atb0),
    .bus(bus)
  );

  always #5 clkin = ~clkin;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_r(input string name, input real act, input real exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit sok_rule();
    return (vddana_0p8 >= 0.76) && (vddana_0p8 <= 0.84) &&
           (vssana >= -0.05) && (vssana <= 0.05) &&
           (iref_25ua >= 22.5e-6) && (iref_25ua <= 27.5e-6);
  endfunction

  function automatic logic [NCH-1:0] mask_of(input int n);
    logic [NCH-1:0] m;
    for (int i = 0; i < NCH; i++) m[i] = (i < n);
    return m;
  endfunction

  // Timeline model: phase plus edges spent in it; enabled count is elapsed/STAGGER.
  int m_ph = 0, m_t = 0, m_nen = 0, m_nen_prev = 0, m_cnt = 0;
  bit m_sticky = 0;
  bit pdb_hist [2];
  bit sok_hist [2];

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_t = 0; m_nen = 0; m_nen_prev = 0; m_cnt = 0; m_sticky = 0;
      pdb_hist[0] = 0; pdb_hist[1] = 0; sok_hist[0] = 0; sok_hist[1] = 0;
    end else begin
      bit ps, ss, flt;
      ps = pdb_hist[1];
      ss = sok_hist[1];
      flt = 0;
      m_nen_prev = m_nen;
      if (m_ph == 0) begin
        if (ps && ss) begin m_ph = 1; m_t = 0; end
      end else if (!ps) begin
        m_ph = 0;
      end else if (!ss) begin
        flt = (m_ph >= 2);
        m_ph = 0;
      end else if (m_ph == 1) begin
        m_t++;
        if (m_t == SETTLE_CYC) begin m_ph = 2; m_t = 0; end
      end else if (m_ph == 2) begin
        m_t++;
        if (m_t / STAGGER_CYC >= NCH) m_ph = 3;
      end
      m_nen = (m_ph == 3) ? NCH : (m_ph == 2) ? m_t / STAGGER_CYC : 0;
      if (flt) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end else if (bus.fault_clr) begin
        m_sticky = 0;
      end
      pdb_hist[1] = pdb_hist[0]; pdb_hist[0] = bus.pdb;
      sok_hist[1] = sok_hist[0]; sok_hist[0] = sok_rule();
    end
  end

  always @(posedge clkin) begin
    if (chk_on) begin
      #2;
      check("clkout_high", {bus.clkout_therm, bus.clkout_bin}, mask_of(m_nen_prev));
      check("clkoutb_high", {bus.clkoutb_therm, bus.clkoutb_bin}, '0);
      check("state", bus.state, 64'(m_ph));
      check("ready", bus.ready, 64'(m_ph == 3));
      check("fault_sticky", bus.fault_sticky, 64'(m_sticky));
      check("fault_cnt", bus.fault_cnt, 64'(m_cnt));
    end
  end

  always @(negedge clkin) begin
    if (chk_on) begin
      bit exp_drive;
      #2;
      check("clkout_low", {bus.clkout_therm, bus.clkout_bin}, '0);
      check("clkoutb_low", {bus.clkoutb_therm, bus.clkoutb_bin}, mask_of(m_nen));
      exp_drive = pdb_hist[1] && (bus.atb_ena != 2'b00);
      check("atb_drive", bus.atb_drive, 64'(exp_drive));
      if (exp_drive) begin
        check_r("atb0", atb0, vssana);
        case (bus.atb_ena)
          2'b01:   check_r("atb1_vdd", atb1, vddana_0p8);
          2'b10:   check_r("atb1_iref", atb1, iref_25ua);
          default: check_r("atb1_rdy", atb1, (m_ph == 3) ? vddana_0p8 : vssana);
        endcase
      end
    end
  end

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clkin);
      #3;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.pdb = 1'b0; bus.atb_ena = 2'b00; bus.fault_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_state", bus.state, 2'b00);
    check("rst_clk", {bus.clkout_therm, bus.clkout_bin, bus.clkoutb_therm, bus.clkoutb_bin}, '0);
    steps(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // Nominal power-up; pdb rises right after edge 0.
    bus.pdb = 1'b1;
    steps(2);  check("e2_state", bus.state, 2'b00);
    steps(1);  check("e3_state", bus.state, 2'b01);
    steps(15); check("e18_state", bus.state, 2'b01);
    steps(1);  check("e19_state", bus.state, 2'b10);
    steps(1);  #4 check("e20_clkoutb_bin", bus.clkoutb_bin, 7'h00);
    steps(1);  #4 check("e21_clkoutb_bin", bus.clkoutb_bin, 7'h01);
    steps(1);  check("e22_clkout_bin", bus.clkout_bin, 7'h01);
    steps(44); check("e66_ready", bus.ready, 1'b0);
    steps(1);  check("e67_ready", bus.ready, 1'b1);
    check("model_e67_phase", 64'(m_ph), 3);
    #4 check("e67_all_on", {bus.clkoutb_therm, bus.clkoutb_bin}, {NCH{1'b1}});

    // pdb drop mid-RAMP, then restart from idx 0.
    bus.pdb = 1'b0; steps(4);
    bus.pdb = 1'b1; steps(39);
    check("e39_state", bus.state, 2'b10);
    bus.pdb = 1'b0;
    steps(2);  check("pdb_drop_e41", bus.state, 2'b10);
    steps(1);  check("pdb_drop_e42", bus.state, 2'b00);
    check("pdb_drop_nofault", bus.fault_sticky, 1'b0);
    #4 check("pdb_drop_clkb", {bus.clkoutb_therm, bus.clkoutb_bin}, '0);
    bus.pdb = 1'b1;
    steps(21); #4 check("restart_idx0", bus.clkoutb_bin, 7'h01);
    steps(46); check("restart_ready", bus.ready, 1'b1);

    // Supply fault from ON and recovery.
    vddana_0p8 = 0.70;
    steps(2);  check("vdd_drop_e2", bus.state, 2'b11);
    steps(1);  check("vdd_drop_e3", bus.state, 2'b00);
    check("fault1_sticky", bus.fault_sticky, 1'b1);
    check("fault1_cnt", bus.fault_cnt, 8'd1);
    check("model_fault1_cnt", 64'(m_cnt), 1);
    vddana_0p8 = 0.8;
    steps(66); check("recover_e66", bus.ready, 1'b0);
    steps(1);  check("recover_e67", bus.ready, 1'b1);

    bus.fault_clr = 1'b1; steps(1); bus.fault_clr = 1'b0;
    check("lone_clr1", bus.fault_sticky, 1'b0);
    vddana_0p8 = 0.70;
    steps(2); bus.fault_clr = 1'b1;
    steps(1); bus.fault_clr = 1'b0;
    check("set_wins_sticky", bus.fault_sticky, 1'b1);
    check("fault2_cnt", bus.fault_cnt, 8'd2);
    steps(2); bus.fault_clr = 1'b1;
    steps(1); bus.fault_clr = 1'b0;
    check("lone_clr2", bus.fault_sticky, 1'b0);

    // Async reset mid clock-high while ON.
    vddana_0p8 = 0.8; vssana = 0.02;
    steps(67); check("pre_rst_ready", bus.ready, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_clkout", {bus.clkout_therm, bus.clkout_bin}, '0);
    check("arst_state", bus.state, 2'b00);
    check("arst_cnt", bus.fault_cnt, 8'd0);
    steps(2); rst = 1'b0;
    steps(2);
    bus.atb_ena = 2'b11; #1;
    check("atb11_drive", bus.atb_drive, 1'b1);
    check_r("atb11_atb1", atb1, 0.02);
    bus.atb_ena = 2'b00; #1;
    check("atb00_hiz", bus.atb_drive, 1'b0);

    // Low reference: never leaves OFF.
    rst = 1'b1; iref_25ua = 20.0e-6; vssana = 0.0;
    steps(2); rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      steps(1);
      check("iref_low_state", bus.state, 2'b00);
    end
    check("iref_low_cnt", bus.fault_cnt, 8'd0);

    // Fault counter saturation: drop supply right after each RAMP entry.
    iref_25ua = 25.0e-6; vddana_0p8 = 0.70;
    reset_pulse();
    steps(5);
    for (int i = 0; i < 258; i++) begin
      vddana_0p8 = 0.8;  steps(20);
      vddana_0p8 = 0.70; steps(4);
    end
    check("sat_cnt", bus.fault_cnt, 8'd255);

    // Random traffic against the model.
    for (int seg = 0; seg < 40; seg++) begin
      int dur;
      bus.pdb = ($urandom_range(0, 4) != 0);
      vddana_0p8 = ($urandom_range(0, 3) != 0) ? (0.78 + 0.02 * $urandom_range(0, 2)) : 0.70;
      iref_25ua  = ($urandom_range(0, 5) != 0) ? (24.0e-6 + 1.0e-6 * $urandom_range(0, 2)) : 20.0e-6;
      vssana     = ($urandom_range(0, 7) != 0) ? (-0.02 + 0.02 * $urandom_range(0, 2)) : 0.1;
      if ($urandom_range(0, 19) == 0) reset_pulse();
      dur = $urandom_range(1, 120);
      for (int c = 0; c < dur; c++) begin
        bus.atb_ena   = 2'($urandom_range(0, 3));
        bus.fault_clr = ($urandom_range(0, 7) == 0);
        steps(1);
      end
    end

    chk_on = 1'b0;
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
